// File: rtl/dm_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the sized data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Size 2'b11 falls into the default arm and behaves as a word.
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_en = 4'b0001 << lo;
      SZ_HALF: lane_en = 4'b0011 << {lo[1], 1'b0};
      default: lane_en = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/dm_sized_mem_if.sv
// Request/response bundle between the MEM stage (master) and the sized data memory (slave).
interface dm_sized_mem_if #(
  parameter int ADDR_W = 12
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              sext;
  logic [31:0]       wdata;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              misalign;

  modport master (
    output req, we, addr, size, sext, wdata,
    input  ready, rvalid, rdata, misalign
  );

  modport slave (
    input  req, we, addr, size, sext, wdata,
    output ready, rvalid, rdata, misalign
  );

endinterface

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering: store-data replication with byte enables,
// and load-lane extraction with sign/zero extension.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_sext,
  input  logic [31:0] rword,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be,
  output logic [31:0] rdata_ext
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be = lane_en(st_size, st_lane);
    case (st_size)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  always_comb begin
    ld_byte = rword[{ld_lane, 3'b000} +: 8];
    ld_half = ld_lane[1] ? rword[31:16] : rword[15:0];
    case (ld_size)
      SZ_BYTE: rdata_ext = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: rdata_ext = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: rdata_ext = rword;
    endcase
  end

endmodule

// File: rtl/dm_sized_mem.sv
// Sized (byte/half/word) data memory with req/ready/rvalid handshake and RD_LAT read latency.
// Optional DM_MISALIGN_EXC_EN: flag misaligned accesses instead of silently aligning them.
module dm_sized_mem
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  dm_sized_mem_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]  ld_idx_reg;
  logic [1:0]        ld_lane_reg, ld_size_reg;
  logic              ld_sext_reg;
  logic [1:0]        rsp_lane_reg, rsp_size_reg;
  logic              rsp_sext_reg;
  logic              rsp_mis_reg;
  logic              misalign_reg;

  logic              ready;
  logic              accept, acc_load, acc_store, wr_en, enter_resp, from_wait;
  logic              cur_mis;
  logic [IDX_W-1:0]  cur_idx, rd_idx;
  logic [31:0]       rword, wdata_rep, rdata_ext;
  logic [3:0]        be;

  assign ready      = (state_reg != S_WAIT);
  assign accept     = bus.req & ready;
  assign acc_load   = accept & ~bus.we;
  assign acc_store  = accept & bus.we;
  assign cur_idx    = bus.addr[ADDR_W-1:2];
  assign from_wait  = (state_reg == S_WAIT);
  assign rd_idx     = from_wait ? ld_idx_reg : cur_idx;
  assign enter_resp = (state_next == S_RESP);
  assign cur_mis    = is_misaligned(bus.size, bus.addr[1:0]);

`ifdef DM_MISALIGN_EXC_EN
  logic ld_mis_reg;
  assign wr_en = acc_store & ~cur_mis & ~rst;
`else
  assign wr_en = acc_store & ~rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_WAIT: begin
        if (cnt_reg == 4'd0) state_next = S_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: begin
        state_next = S_IDLE;
        if (acc_load) begin
          if (RD_LAT == 1) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = 4'(RD_LAT - 2);
          end
        end
      end
    endcase
  end

  // Request fields are captured at accept; the response view is captured when
  // the array is read so a back-to-back accept cannot disturb held rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_idx_reg   <= '0;
      ld_lane_reg  <= 2'd0;
      ld_size_reg  <= 2'd0;
      ld_sext_reg  <= 1'b0;
      rsp_lane_reg <= 2'd0;
      rsp_size_reg <= 2'd0;
      rsp_sext_reg <= 1'b0;
      rsp_mis_reg  <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      if (accept) begin
        ld_idx_reg  <= cur_idx;
        ld_lane_reg <= bus.addr[1:0];
        ld_size_reg <= bus.size;
        ld_sext_reg <= bus.sext;
      end
      if (enter_resp) begin
        rsp_lane_reg <= from_wait ? ld_lane_reg : bus.addr[1:0];
        rsp_size_reg <= from_wait ? ld_size_reg : bus.size;
        rsp_sext_reg <= from_wait ? ld_sext_reg : bus.sext;
      end
`ifdef DM_MISALIGN_EXC_EN
      misalign_reg <= accept & cur_mis;
      if (enter_resp) rsp_mis_reg <= from_wait ? ld_mis_reg : cur_mis;
`else
      misalign_reg <= 1'b0;
      rsp_mis_reg  <= 1'b0;
`endif
    end
  end

`ifdef DM_MISALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (rst)         ld_mis_reg <= 1'b0;
    else if (accept) ld_mis_reg <= cur_mis;
  end
`endif

  // One inferred RAM per byte lane, each with a registered read port.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rbyte_reg;

      always_ff @(posedge clk) begin
        if (wr_en && be[gi]) lane_mem[cur_idx] <= wdata_rep[8*gi +: 8];
      end

      always_ff @(posedge clk) begin
        if (rst)             rbyte_reg <= 8'd0;
        else if (enter_resp) rbyte_reg <= lane_mem[rd_idx];
      end

      assign rword[8*gi +: 8] = rbyte_reg;
    end
  endgenerate

  dm_lane_align u_align (
    .st_size   (bus.size),
    .st_lane   (bus.addr[1:0]),
    .wdata     (bus.wdata),
    .ld_size   (rsp_size_reg),
    .ld_lane   (rsp_lane_reg),
    .ld_sext   (rsp_sext_reg),
    .rword     (rword),
    .wdata_rep (wdata_rep),
    .be        (be),
    .rdata_ext (rdata_ext)
  );

  assign bus.ready    = ready;
  assign bus.rvalid   = (state_reg == S_RESP);
  assign bus.rdata    = rsp_mis_reg ? 32'd0 : rdata_ext;
  assign bus.misalign = misalign_reg;

endmodule

// File: tb/tb_dm_sized_mem.sv
// Directed bench for dm_sized_mem: one RD_LAT=1 and one RD_LAT=3 instance on a shared clock/reset.
module tb_dm_sized_mem;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_sized_mem_if #(.ADDR_W(12)) m1 ();
  dm_sized_mem_if #(.ADDR_W(12)) m3 ();

  dm_sized_mem #(.ADDR_W(12), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(m1.slave));
  dm_sized_mem #(.ADDR_W(12), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(m3.slave));

  int checks = 0;
  int errors = 0;

  function automatic logic get_ready(input bit sel);
    return sel ? m3.ready : m1.ready;
  endfunction
  function automatic logic get_rvalid(input bit sel);
    return sel ? m3.rvalid : m1.rvalid;
  endfunction
  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? m3.rdata : m1.rdata;
  endfunction

  task automatic drive(input bit sel, input logic rq, input logic w, input logic [11:0] a,
                       input logic [1:0] sz, input logic sx, input logic [31:0] wd);
    if (sel) begin
      m3.req = rq; m3.we = w; m3.addr = a; m3.size = sz; m3.sext = sx; m3.wdata = wd;
    end else begin
      m1.req = rq; m1.we = w; m1.addr = a; m1.size = sz; m1.sext = sx; m1.wdata = wd;
    end
  endtask

  // Issue one access; for loads, return data and cycles from accept edge to rvalid.
  task automatic access(input bit sel, input logic w, input logic [11:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd, output logic [31:0] data,
                        output int lat);
    int k;
    data = 32'hx;
    lat  = 0;
    drive(sel, 1'b1, w, a, sz, sx, wd);
    k = 0;
    while (!get_ready(sel) && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!get_ready(sel)) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready=%b required 1 within 20 cycles", get_ready(sel));
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, w, a, sz, sx, wd);
    if (!w) begin
      lat = 1;
      while (!get_rvalid(sel) && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      if (get_rvalid(sel)) data = get_rdata(sel);
      else begin
        checks++; errors++;
        $display("FAIL rvalid_timeout: rvalid=0 required 1 within 20 cycles");
      end
    end
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 1'b0, 12'h0, SZ_WORD, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 12'h0, SZ_WORD, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m1.ready !== 1'b1)    begin errors++; $display("FAIL reset_ready1: got %b expected 1", m1.ready); end
    checks++; if (m1.rvalid !== 1'b0)   begin errors++; $display("FAIL reset_rvalid1: got %b expected 0", m1.rvalid); end
    checks++; if (m1.rdata !== 32'h0)   begin errors++; $display("FAIL reset_rdata1: got %h expected 0", m1.rdata); end
    checks++; if (m1.misalign !== 1'b0) begin errors++; $display("FAIL reset_mis1: got %b expected 0", m1.misalign); end
    checks++; if (m3.ready !== 1'b1)    begin errors++; $display("FAIL reset_ready3: got %b expected 1", m3.ready); end
    checks++; if (m3.rvalid !== 1'b0)   begin errors++; $display("FAIL reset_rvalid3: got %b expected 0", m3.rvalid); end
    checks++; if (m3.rdata !== 32'h0)   begin errors++; $display("FAIL reset_rdata3: got %h expected 0", m3.rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_word;
    logic [31:0] d; int lat;
    access(1'b0, 1'b1, 12'h010, SZ_WORD, 1'b0, 32'hDEADBEEF, d, lat);
    access(1'b0, 1'b0, 12'h010, SZ_WORD, 1'b0, 32'h0, d, lat);
    $display("LW @010 -> %h lat %0d", d, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL lw_latency: got %0d expected 1", lat); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", d); end
    @(posedge clk); #1;
    checks++; if (m1.rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b expected 0", m1.rvalid); end
    checks++; if (m1.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef", m1.rdata); end
  endtask

  task automatic test_byte;
    logic [31:0] d; int lat;
    access(1'b0, 1'b1, 12'h013, SZ_BYTE, 1'b0, 32'h00000080, d, lat);
    access(1'b0, 1'b0, 12'h013, SZ_BYTE, 1'b1, 32'h0, d, lat);
    $display("LB @013 -> %h", d);
    checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h expected ffffff80", d); end
    access(1'b0, 1'b0, 12'h013, SZ_BYTE, 1'b0, 32'h0, d, lat);
    $display("LBU @013 -> %h", d);
    checks++; if (d !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h expected 00000080", d); end
    access(1'b0, 1'b0, 12'h010, SZ_WORD, 1'b0, 32'h0, d, lat);
    $display("LW @010 -> %h", d);
    checks++; if (d !== 32'h80ADBEEF) begin errors++; $display("FAIL sb_merge: got %h expected 80adbeef", d); end
  endtask

  task automatic test_half;
    logic [31:0] d; int lat;
    access(1'b0, 1'b1, 12'h020, SZ_WORD, 1'b0, 32'hAAAAAAAA, d, lat);
    access(1'b0, 1'b1, 12'h022, SZ_HALF, 1'b0, 32'h00001234, d, lat);
    access(1'b0, 1'b0, 12'h020, SZ_WORD, 1'b0, 32'h0, d, lat);
    $display("LW @020 -> %h", d);
    checks++; if (d !== 32'h1234AAAA) begin errors++; $display("FAIL sh_merge: got %h expected 1234aaaa", d); end
    access(1'b0, 1'b0, 12'h022, SZ_HALF, 1'b1, 32'h0, d, lat);
    $display("LH @022 -> %h", d);
    checks++; if (d !== 32'h00001234) begin errors++; $display("FAIL lh_upper: got %h expected 00001234", d); end
    access(1'b0, 1'b0, 12'h020, SZ_HALF, 1'b1, 32'h0, d, lat);
    $display("LH @020 -> %h", d);
    checks++; if (d !== 32'hFFFFAAAA) begin errors++; $display("FAIL lh_sext: got %h expected ffffaaaa", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; int lat;
    access(1'b1, 1'b1, 12'h040, SZ_WORD, 1'b0, 32'hCAFEF00D, d, lat);
    access(1'b1, 1'b1, 12'h044, SZ_WORD, 1'b0, 32'h01020304, d, lat);
    drive(1'b1, 1'b1, 1'b0, 12'h040, SZ_WORD, 1'b0, 32'h0);
    @(posedge clk); #1;  // cycle 1
    checks++; if (m3.ready !== 1'b0)  begin errors++; $display("FAIL wait_ready_c1: got %b expected 0", m3.ready); end
    checks++; if (m3.rvalid !== 1'b0) begin errors++; $display("FAIL wait_rvalid_c1: got %b expected 0", m3.rvalid); end
    drive(1'b1, 1'b1, 1'b0, 12'h044, SZ_WORD, 1'b0, 32'h0);
    @(posedge clk); #1;  // cycle 2
    checks++; if (m3.ready !== 1'b0)  begin errors++; $display("FAIL wait_ready_c2: got %b expected 0", m3.ready); end
    @(posedge clk); #1;  // cycle 3
    $display("lat3 cycle3 rvalid=%b rdata=%h", m3.rvalid, m3.rdata);
    checks++; if (m3.rvalid !== 1'b1) begin errors++; $display("FAIL resp_rvalid_c3: got %b expected 1", m3.rvalid); end
    checks++; if (m3.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL resp_rdata_c3: got %h expected cafef00d", m3.rdata); end
    checks++; if (m3.ready !== 1'b1)  begin errors++; $display("FAIL resp_ready_c3: got %b expected 1", m3.ready); end
    @(posedge clk); #1;  // cycle 4, second load accepted at previous edge
    m3.req = 1'b0;
    checks++; if (m3.ready !== 1'b0)  begin errors++; $display("FAIL b2b_ready_c4: got %b expected 0", m3.ready); end
    @(posedge clk); #1;  // cycle 5
    checks++; if (m3.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_c5: got %b expected 0", m3.rvalid); end
    @(posedge clk); #1;  // cycle 6
    $display("lat3 cycle6 rvalid=%b rdata=%h", m3.rvalid, m3.rdata);
    checks++; if (m3.rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid_c6: got %b expected 1", m3.rvalid); end
    checks++; if (m3.rdata !== 32'h01020304) begin errors++; $display("FAIL b2b_rdata_c6: got %h expected 01020304", m3.rdata); end
  endtask

  task automatic test_abort;
    logic [31:0] d; int lat; int seen;
    drive(1'b1, 1'b1, 1'b0, 12'h040, SZ_WORD, 1'b0, 32'h0);
    @(posedge clk); #1;
    m3.req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (m3.ready !== 1'b1)  begin errors++; $display("FAIL abort_ready: got %b expected 1", m3.ready); end
    checks++; if (m3.rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", m3.rdata); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (m3.rvalid) seen++;
      @(posedge clk); #1;
    end
    $display("abort: rvalid seen %0d times", seen);
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_rvalid: got %0d expected 0", seen); end
    access(1'b1, 1'b0, 12'h040, SZ_WORD, 1'b0, 32'h0, d, lat);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_mem3: got %h expected cafef00d", d); end
    checks++; if (lat != 3) begin errors++; $display("FAIL abort_lat3: got %0d expected 3", lat); end
    access(1'b0, 1'b0, 12'h010, SZ_WORD, 1'b0, 32'h0, d, lat);
    checks++; if (d !== 32'h80ADBEEF) begin errors++; $display("FAIL abort_mem1: got %h expected 80adbeef", d); end
  endtask

  task automatic test_misalign;
    logic [31:0] d; int lat;
    logic        exp_mis;
    logic [31:0] exp_word, exp_half;
`ifdef DM_MISALIGN_EXC_EN
    exp_mis = 1'b1; exp_word = 32'h55667788; exp_half = 32'h00000000;
`else
    exp_mis = 1'b0; exp_word = 32'h11223344; exp_half = 32'h00003344;
`endif
    access(1'b0, 1'b1, 12'h030, SZ_WORD, 1'b0, 32'h55667788, d, lat);
    drive(1'b0, 1'b1, 1'b1, 12'h031, SZ_WORD, 1'b0, 32'h11223344);
    @(posedge clk); #1;
    m1.req = 1'b0;
    $display("SW @031 misalign=%b", m1.misalign);
    checks++; if (m1.misalign !== exp_mis) begin errors++; $display("FAIL mis_pulse: got %b expected %b", m1.misalign, exp_mis); end
    @(posedge clk); #1;
    checks++; if (m1.misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", m1.misalign); end
    access(1'b0, 1'b0, 12'h030, SZ_WORD, 1'b0, 32'h0, d, lat);
    $display("LW @030 -> %h", d);
    checks++; if (d !== exp_word) begin errors++; $display("FAIL mis_word: got %h expected %h", d, exp_word); end
    access(1'b0, 1'b0, 12'h031, SZ_HALF, 1'b0, 32'h0, d, lat);
    $display("LHU @031 -> %h", d);
    checks++; if (d !== exp_half) begin errors++; $display("FAIL mis_half: got %h expected %h", d, exp_half); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_back_to_back;
    test_abort;
    test_misalign;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
